// File: rtl/mcu_debug_responder.sv
// Debug command endpoint for the RISC-V core: halts, resumes and resets the core,
// and gives register-file and memory access while the core is halted.
module mcu_debug_responder #(
   parameter int RST_CYCLES  = 4,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic        pause,
   input  logic        resume,
   input  logic        reset,
   input  logic        reg_rd,
   input  logic        reg_wr,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic        mem_rw_byte,
   input  logic [31:0] addr,
   input  logic [31:0] d_in,
   output logic        mcu_busy,
   output logic [31:0] d_rd,
   output logic [31:0] pc,
   output logic        dbg_err,
   output logic        halted,
   output logic        core_pause,
   input  logic        core_at_boundary,
   input  logic [31:0] core_pc,
   output logic        core_reset,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_wd,
   output logic        rf_we,
   input  logic [31:0] rf_rd,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   output logic [3:0]  mem_be,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [2:0] {IDLE, HALT_WAIT, RST_PULSE, REG, MEM, DONE} state_t;
   typedef enum logic [2:0] {
      C_NONE, C_PAUSE, C_RESUME, C_RESET, C_REG_RD, C_REG_WR, C_MEM_RD, C_MEM_WR
   } cmd_t;

   state_t      state;
   cmd_t        cmd;
   cmd_t        cmd_sel;
   logic [3:0]  rst_cnt;
   logic [7:0]  to_cnt;
   logic        byte_acc;
   logic [1:0]  boff;

   function automatic logic [31:0] byte_lane(input logic [31:0] w, input logic [1:0] off);
      return {24'd0, w[8*off +: 8]};
   endfunction

   function automatic logic [3:0] byte_en(input logic is_byte, input logic [1:0] off);
      return is_byte ? (4'b0001 << off) : 4'hF;
   endfunction

   always_comb begin
      cmd_sel = C_NONE;
      if (pause)       cmd_sel = C_PAUSE;
      else if (resume) cmd_sel = C_RESUME;
      else if (reset)  cmd_sel = C_RESET;
      else if (reg_rd) cmd_sel = C_REG_RD;
      else if (reg_wr) cmd_sel = C_REG_WR;
      else if (mem_rd) cmd_sel = C_MEM_RD;
      else if (mem_wr) cmd_sel = C_MEM_WR;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cmd        <= C_NONE;
         rst_cnt    <= '0;
         to_cnt     <= '0;
         byte_acc   <= 1'b0;
         boff       <= '0;
         mcu_busy   <= 1'b0;
         d_rd       <= '0;
         pc         <= '0;
         dbg_err    <= 1'b0;
         halted     <= 1'b0;
         core_pause <= 1'b0;
         core_reset <= 1'b0;
         rf_addr    <= '0;
         rf_wd      <= '0;
         rf_we      <= 1'b0;
         mem_addr   <= '0;
         mem_wd     <= '0;
         mem_be     <= '0;
         mem_re     <= 1'b0;
         mem_we     <= 1'b0;
      end else begin
         dbg_err <= 1'b0;
         case (state)
            IDLE: begin
               if (valid && cmd_sel != C_NONE) begin
                  cmd      <= cmd_sel;
                  mcu_busy <= 1'b1;
                  case (cmd_sel)
                     C_PAUSE: begin
                        if (halted) state <= DONE;
                        else begin
                           core_pause <= 1'b1;
                           state      <= HALT_WAIT;
                        end
                     end
                     // resume spends a cycle in HALT_WAIT so its latency matches pause/reg
                     C_RESUME: state <= HALT_WAIT;
                     C_RESET: begin
                        core_reset <= 1'b1;
                        pc         <= '0;
                        rst_cnt    <= 4'(RST_CYCLES - 1);
                        state      <= RST_PULSE;
                     end
                     C_REG_RD, C_REG_WR: begin
                        if (!halted) begin
                           dbg_err <= 1'b1;
                           state   <= DONE;
                        end else begin
                           rf_addr <= addr[4:0];
                           rf_wd   <= d_in;
                           rf_we   <= (cmd_sel == C_REG_WR) && (addr[4:0] != 5'd0);
                           state   <= REG;
                        end
                     end
                     default: begin
                        if (!halted || (!mem_rw_byte && addr[1:0] != 2'b00)) begin
                           dbg_err <= 1'b1;
                           state   <= DONE;
                        end else begin
                           mem_addr <= {addr[31:2], 2'b00};
                           mem_be   <= byte_en(mem_rw_byte, addr[1:0]);
                           mem_wd   <= mem_rw_byte ? {4{d_in[7:0]}} : d_in;
                           mem_re   <= (cmd_sel == C_MEM_RD);
                           mem_we   <= (cmd_sel == C_MEM_WR);
                           byte_acc <= mem_rw_byte;
                           boff     <= addr[1:0];
                           to_cnt   <= '0;
                           state    <= MEM;
                        end
                     end
                  endcase
               end
            end
            HALT_WAIT: begin
               if (cmd == C_RESUME) begin
                  core_pause <= 1'b0;
                  halted     <= 1'b0;
                  state      <= DONE;
               end else if (core_at_boundary) begin
                  halted <= 1'b1;
                  pc     <= core_pc;
                  state  <= DONE;
               end
            end
            RST_PULSE: begin
               if (rst_cnt == 4'd0) begin
                  core_reset <= 1'b0;
                  state      <= DONE;
               end else begin
                  rst_cnt <= rst_cnt - 4'd1;
               end
            end
            REG: begin
               if (cmd == C_REG_RD) d_rd <= rf_rd;
               rf_we <= 1'b0;
               state <= DONE;
            end
            MEM: begin
               if (mem_ack) begin
                  if (mem_re) d_rd <= byte_acc ? byte_lane(mem_rdata, boff) : mem_rdata;
                  mem_re <= 1'b0;
                  mem_we <= 1'b0;
                  state  <= DONE;
               end else if (to_cnt == 8'(MEM_TIMEOUT - 1)) begin
                  mem_re  <= 1'b0;
                  mem_we  <= 1'b0;
                  d_rd    <= '0;
                  dbg_err <= 1'b1;
                  state   <= DONE;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
            end
            DONE: begin
               mcu_busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mcu_debug_responder.sv
// Scoreboard bench for mcu_debug_responder: a byte-level reference model predicts each
// command's outcome; a monitor checks it when mcu_busy falls.
module tb_mcu_debug_responder;

   logic        clk, rst, valid;
   logic        pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr, mem_rw_byte;
   logic [31:0] addr, d_in;
   logic        mcu_busy, dbg_err, halted, core_pause, core_reset, rf_we;
   logic [31:0] d_rd, pc, rf_wd, rf_rd, mem_addr, mem_wd, mem_rdata;
   logic        core_at_boundary, mem_re, mem_we, mem_ack;
   logic [31:0] core_pc;
   logic [4:0]  rf_addr;
   logic [3:0]  mem_be;

   mcu_debug_responder #(.RST_CYCLES(4), .MEM_TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .valid(valid), .pause(pause), .resume(resume), .reset(reset),
      .reg_rd(reg_rd), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_rw_byte(mem_rw_byte), .addr(addr), .d_in(d_in), .mcu_busy(mcu_busy),
      .d_rd(d_rd), .pc(pc), .dbg_err(dbg_err), .halted(halted), .core_pause(core_pause),
      .core_at_boundary(core_at_boundary), .core_pc(core_pc), .core_reset(core_reset),
      .rf_addr(rf_addr), .rf_wd(rf_wd), .rf_we(rf_we), .rf_rd(rf_rd),
      .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_be(mem_be), .mem_re(mem_re),
      .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // environment: register file and word memory seen by the DUT
   logic [31:0] rf_arr [32] = '{default: 32'd0};
   assign rf_rd = rf_arr[rf_addr];
   always @(posedge clk) if (rf_we) rf_arr[rf_addr] <= rf_wd;

   logic [31:0] env_mem [bit [31:0]];
   bit no_ack = 1'b0;
   int ack_delay = 0;

   initial begin
      int wcnt = 0;
      logic [31:0] w;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if ((mem_re || mem_we) && !no_ack && !rst) begin
            if (wcnt >= ack_delay) begin
               wcnt = 0;
               w = env_mem.exists(mem_addr) ? env_mem[mem_addr] : 32'd0;
               mem_rdata = w;
               mem_ack = 1'b1;
               if (mem_we) begin
                  for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wd[8*i +: 8];
                  env_mem[mem_addr] = w;
               end
            end else wcnt++;
         end else wcnt = 0;
      end
   end

   // reference model
   typedef struct {logic [31:0] d; logic err; logic hlt; logic [31:0] pcv;} exp_t;
   exp_t q[$];
   logic        m_halt = 1'b0;
   logic [31:0] m_pc = '0, m_d = '0;
   logic [31:0] m_rf [32] = '{default: 32'd0};
   logic [7:0]  mb [bit [31:0]];

   function automatic logic [7:0] rdb(input logic [31:0] a);
      return mb.exists(a) ? mb[a] : 8'd0;
   endfunction

   task automatic model_cmd(input int k, input logic byt, input logic [31:0] a, d, input bit tmo);
      exp_t e;
      logic err = 1'b0;
      case (k)
         0: if (!m_halt) begin m_halt = 1'b1; m_pc = core_pc; end
         1: m_halt = 1'b0;
         2: m_pc = '0;
         3, 4: begin
            if (!m_halt) err = 1'b1;
            else if (k == 3) m_d = m_rf[a[4:0]];
            else if (a[4:0] != 5'd0) m_rf[a[4:0]] = d;
         end
         default: begin
            if (!m_halt || (!byt && a[1:0] != 2'b00)) err = 1'b1;
            else if (tmo) begin err = 1'b1; m_d = '0; end
            else if (k == 5) m_d = byt ? {24'd0, rdb(a)} : {rdb(a + 3), rdb(a + 2), rdb(a + 1), rdb(a)};
            else if (byt) mb[a] = d[7:0];
            else for (int i = 0; i < 4; i++) mb[a + i] = d[8*i +: 8];
         end
      endcase
      e.d = m_d; e.err = err; e.hlt = m_halt; e.pcv = m_pc;
      q.push_back(e);
   endtask

   // monitor: one expectation per command, checked as mcu_busy falls
   logic prev_busy = 1'b0, err_seen = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_busy = 1'b0;
         err_seen  = 1'b0;
      end else begin
         if (mcu_busy && dbg_err) err_seen = 1'b1;
         if (prev_busy && !mcu_busy) begin
            if (q.size() == 0) chk("sb_unexpected_done", 1, 0);
            else begin
               e = q.pop_front();
               chk("sb_d_rd", d_rd, e.d);
               chk("sb_dbg_err", err_seen, e.err);
               chk("sb_halted", halted, e.hlt);
               chk("sb_pc", pc, e.pcv);
            end
            err_seen = 1'b0;
         end
         prev_busy = mcu_busy;
      end
   end

   task automatic issue(input logic [6:0] sel, input logic byt, input logic [31:0] a, d);
      int k = -1;
      for (int i = 0; i < 7; i++) if (sel[i] && k < 0) k = i;
      @(negedge clk);
      valid = 1'b1;
      {mem_wr, mem_rd, reg_wr, reg_rd, reset, resume, pause} = sel;
      mem_rw_byte = byt; addr = a; d_in = d;
      if (k >= 0) model_cmd(k, byt, a, d, no_ack);
      @(negedge clk);
      valid = 1'b0;
      {mem_wr, mem_rd, reg_wr, reg_rd, reset, resume, pause} = '0;
   endtask

   int cyc, we_n, re_n, rfwe_n, crst_n;
   logic [3:0]  be1;
   logic [31:0] wd1;

   task automatic wait_idle(input int bdy_at);
      cyc = 0; we_n = 0; re_n = 0; rfwe_n = 0; crst_n = 0;
      while (mcu_busy && cyc < 1000) begin
         cyc++;
         if (cyc == bdy_at) core_at_boundary = 1'b1;
         if (mem_we) we_n++;
         if (mem_re) re_n++;
         if (rf_we) rfwe_n++;
         if (core_reset) crst_n++;
         if (cyc == 1) begin be1 = mem_be; wd1 = mem_wd; end
         @(negedge clk);
      end
      if (cyc >= 1000) chk("busy_timeout", 1, 0);
   endtask

   localparam logic [6:0] S_PAUSE = 7'b0000001, S_RESUME = 7'b0000010, S_RESET = 7'b0000100,
                          S_REG_RD = 7'b0001000, S_REG_WR = 7'b0010000,
                          S_MEM_RD = 7'b0100000, S_MEM_WR = 7'b1000000;

   initial begin
      logic [31:0] a;
      logic [6:0]  sel;
      int k, b;
      logic byt;
      rst = 1'b1; valid = 1'b0;
      {mem_wr, mem_rd, reg_wr, reg_rd, reset, resume, pause} = '0;
      mem_rw_byte = 1'b0; addr = '0; d_in = '0;
      core_at_boundary = 1'b0; core_pc = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", mcu_busy, 0);
      chk("rst_d_rd", d_rd, 0);
      chk("rst_pc", pc, 0);
      chk("rst_ctrl", {halted, core_pause, core_reset, dbg_err, rf_we, mem_re, mem_we}, 0);
      chk("rst_mem_be", mem_be, 0);
      rst = 1'b0;

      // valid with no select is a no-op
      issue(7'd0, 1'b0, 32'd0, 32'd0);
      chk("noop_busy", mcu_busy, 0);

      // commands rejected while running
      issue(S_REG_WR, 1'b0, 32'd3, 32'h1234_5678); wait_idle(0);
      chk("nohalt_rf_we", rfwe_n, 0);
      issue(S_REG_RD, 1'b0, 32'd3, 32'd0); wait_idle(0);

      // pause with boundary low for 5 cycles
      core_pc = 32'h0000_0104;
      issue(S_PAUSE, 1'b0, 32'd0, 32'd0);
      chk("pause_core_pause", core_pause, 1);
      wait_idle(6);
      chk("pause_busy_cycles", cyc, 7);
      chk("pause_pc", pc, 32'h104);
      core_at_boundary = 1'b0;

      // register access
      issue(S_REG_WR, 1'b0, 32'd3, 32'hCAFE_F00D); wait_idle(0);
      chk("regwr_rf_we", rfwe_n, 1);
      chk("regwr_busy_cycles", cyc, 2);
      issue(S_REG_RD, 1'b0, 32'd3, 32'd0); wait_idle(0);
      chk("regrd_d_rd", d_rd, 32'hCAFE_F00D);
      chk("regrd_busy_cycles", cyc, 2);
      issue(S_REG_WR, 1'b0, 32'd0, 32'hFFFF_FFFF); wait_idle(0);
      chk("regwr_x0_rf_we", rfwe_n, 0);

      // byte memory access with slow ack
      ack_delay = 3;
      issue(S_MEM_WR, 1'b1, 32'h102, 32'h0000_00AB); wait_idle(0);
      chk("bwr_mem_be", be1, 4'b0100);
      chk("bwr_mem_wd", wd1, 32'hABAB_ABAB);
      chk("bwr_we_cycles", we_n, 4);
      chk("bwr_env_word", env_mem[32'h100], 32'h00AB_0000);
      issue(S_MEM_RD, 1'b1, 32'h102, 32'd0); wait_idle(0);
      chk("brd_d_rd", d_rd, 32'h0000_00AB);
      ack_delay = 0;

      // misaligned word and timeout
      issue(S_MEM_RD, 1'b0, 32'h101, 32'd0); wait_idle(0);
      chk("misalign_no_re", re_n, 0);
      no_ack = 1'b1;
      issue(S_MEM_RD, 1'b0, 32'h100, 32'd0); wait_idle(0);
      chk("timeout_re_cycles", re_n, 255);
      chk("timeout_d_rd", d_rd, 0);
      no_ack = 1'b0;

      // resume, then pause+mem_wr together executes pause only
      issue(S_RESUME, 1'b0, 32'd0, 32'd0); wait_idle(0);
      chk("resume_busy_cycles", cyc, 2);
      chk("resume_core_pause", core_pause, 0);
      core_at_boundary = 1'b1; core_pc = 32'h0000_0200;
      issue(S_PAUSE | S_MEM_WR, 1'b0, 32'h100, 32'h5555_5555); wait_idle(0);
      chk("prio_no_mem_we", we_n, 0);
      chk("prio_busy_cycles", cyc, 2);

      // core reset pulse while halted
      issue(S_RESET, 1'b0, 32'd0, 32'd0); wait_idle(0);
      chk("reset_pulse_cycles", crst_n, 4);
      chk("reset_keeps_pause", core_pause, 1);

      // reset while running; a strobe during the pulse is ignored
      issue(S_RESUME, 1'b0, 32'd0, 32'd0); wait_idle(0);
      issue(S_RESET, 1'b0, 32'd0, 32'd0);
      @(negedge clk); valid = 1'b1; pause = 1'b1;
      @(negedge clk); valid = 1'b0; pause = 1'b0;
      wait_idle(0);
      repeat (2) @(negedge clk);
      chk("busy_strobe_ignored_busy", mcu_busy, 0);
      chk("busy_strobe_ignored_pause", core_pause, 0);

      // randomized command stream
      for (int n = 0; n < 80; n++) begin
         k = $urandom_range(0, 9);
         case (k)
            0, 1: b = 0;
            2: b = 1;
            3: b = 2;
            4, 5: b = 3;
            6: b = 4;
            7: b = 5;
            default: b = 6;
         endcase
         sel = 7'(1 << b);
         if ($urandom_range(0, 3) == 0) sel = sel | (7'($urandom_range(0, 127)) & ~7'((2 << b) - 1));
         byt = 1'($urandom_range(0, 1));
         a = $urandom();
         if (b >= 5) begin
            a = 32'h100 + 32'($urandom_range(0, 15));
            if (!byt && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         end else a[4:0] = 5'($urandom_range(0, 7));
         ack_delay = $urandom_range(0, 4);
         core_pc = $urandom();
         k = $urandom_range(0, 4);
         core_at_boundary = (k == 0);
         issue(sel, byt, a, $urandom());
         wait_idle(k);
         core_at_boundary = 1'b0;
      end

      // asynchronous reset during a memory wait
      core_at_boundary = 1'b1;
      issue(S_PAUSE, 1'b0, 32'd0, 32'd0); wait_idle(0);
      no_ack = 1'b1;
      issue(S_MEM_RD, 1'b0, 32'h104, 32'd0);
      repeat (3) @(negedge clk);
      chk("abort_re_before", mem_re, 1);
      @(posedge clk); #2 rst = 1'b1; #1;
      chk("abort_mem_re", mem_re, 0);
      chk("abort_busy", mcu_busy, 0);
      chk("abort_halted", halted, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0; no_ack = 1'b0;
      void'(q.pop_back());
      m_halt = 1'b0; m_pc = '0; m_d = '0;
      issue(S_REG_RD, 1'b0, 32'd3, 32'd0); wait_idle(0);
      repeat (2) @(negedge clk);
      chk("sb_drained", q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
